wb_regfile_stage: RTL and testbench

- Parametrised writeback stage with integrated register file for the Y86-64 pipeline; sits after memory stage, feeds decode read ports.
- Decodes icode/ifun/cnd into dstE/dstM, commits valE/valM on rising clk, and tracks pipeline status with a RUN/HALT state machine.
- Adds over the previous writeback: synchronous reset, configurable width/register count, valid qualification, status-driven halt, and a retired-instruction counter.

---
 rtl/wb_regfile_stage.sv | 196 +++++++++++++++++++
 tb/tb_wb_regfile_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_stage.sv
// -----------------------------------------------------------------------------
// wb_regfile_stage
//
// This is the Y86-64 writeback stage with the architectural register file built
// in. It sits after the memory stage and drives the decode-stage read ports.
//
// What it does:
//   - Decodes icode/ifun/cnd into the destination indices dstE and dstM.
//   - Commits valE/valM to the register file on the rising clock edge.
//   - Runs a RUN/HALT state machine. The first valid instruction whose status
//     is not AOK halts the stage. That state holds until reset.
//   - Counts committed instructions in a saturating counter.
//
// Optional feature:
//   - Defining WB_BYPASS_EN makes the read ports forward the value being
//     committed this cycle when the address matches (write-through).
//   - Left undefined, reads return only the stored value.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   wb_valid   an instruction is present this cycle (low = bubble)
//   icode      instruction code
//   ifun       function code
//   cnd        condition result from execute (cmovXX taken)
//   rA, rB     register specifiers
//   valE       ALU result
//   valM       memory result
//   stat       instruction status: AOK=1, HLT=2, ADR=3, INS=4
//   srcA, srcB decode read addresses
//   rdA, rdB   read data; 0 for address 4'hF or an address >= NUM_REGS
//   dstE, dstM decoded destinations, 4'hF when there is none
//   halted     the state machine is in HALT
//   wb_stat    status of the last accepted instruction
//   retired    number of committed instructions, saturating
// -----------------------------------------------------------------------------
module wb_regfile_stage #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int RSP_IDX  = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [2:0]        stat,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rdA,
  output logic [DATA_W-1:0] rdB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic              halted,
  output logic [2:0]        wb_stat,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_IDX);

  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              commit;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Destination decode. This is combinational and ignores wb_valid, so the
  // hazard logic still sees the destinations during a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: give every always_comb output a default first. A path that leaves
    // an output unassigned infers a latch.
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      I_MRMOVQ: dstM = rA;
      I_POPQ: begin
        dstM = rA;
        dstE = RSP;
      end
      I_IRMOVQ, I_OPQ:         dstE = rB;
      I_RRMOVQ:                dstE = (ifun == 4'h0 || cnd) ? rB : RNONE;
      I_PUSHQ, I_CALL, I_RET:  dstE = RSP;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline status state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
    // then samples values from before the edge, whatever order the blocks run.
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wb_valid && stat != STAT_AOK) state_d = HALT;
      HALT:    state_d = HALT;  // stays here until reset
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted = (state_q == HALT);
  end

  // An instruction that is not AOK is accepted for wb_stat, but it never writes.
  assign commit = wb_valid && (state_q == RUN) && (stat == STAT_AOK);

  // ---------------------------------------------------------------------------
  // Register file. The loop covers only indices below NUM_REGS and excludes
  // RNONE, so writes to any other index are dropped. When dstE equals dstM,
  // valM wins, which gives popq %rsp its architectural result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: this array is reset on purpose, because the architecture defines
    // all registers as 0 after reset. That keeps it in flops rather than RAM.
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (4'(i) != RNONE) begin
          if (dstM == 4'(i))      regs[i] <= valM;
          else if (dstE == 4'(i)) regs[i] <= valE;
        end
      end
    end
  end

  // Read port. Addresses outside the file, and RNONE, return 0.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (4'(i) != RNONE && src == 4'(i)) begin
        data = regs[i];
`ifdef WB_BYPASS_EN
        // Forward the value being committed. dstM is checked last so that
        // its value takes priority.
        if (commit && dstE == src) data = valE;
        if (commit && dstM == src) data = valM;
`endif
      end
    end
    return data;
  endfunction

  always_comb begin
    rdA = read_port(srcA);
    rdB = read_port(srcB);
  end

  // ---------------------------------------------------------------------------
  // Status of the last accepted instruction. It is held while in HALT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)                          wb_stat <= STAT_AOK;
    else if (wb_valid && state_q == RUN) wb_stat <= stat;
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter. It saturates at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)                      retired <= '0;
    else if (commit && retired != '1) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_stage
//
// Directed testbench for wb_regfile_stage. It uses the default parameters.
// Expected values are hand-computed constants. Inputs are driven 1 time unit
// after the rising edge. Registered results are sampled 1 time unit after the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_wb_regfile_stage;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        cnd;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] rdA;
  logic [63:0] rdB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic        halted;
  logic [2:0]  wb_stat;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  wb_regfile_stage dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .icode    (icode),
    .ifun     (ifun),
    .cnd      (cnd),
    .rA       (rA),
    .rB       (rB),
    .valE     (valE),
    .valM     (valM),
    .stat     (stat),
    .srcA     (srcA),
    .srcB     (srcB),
    .rdA      (rdA),
    .rdB      (rdB),
    .dstE     (dstE),
    .dstM     (dstM),
    .halted   (halted),
    .wb_stat  (wb_stat),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic c, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] e, input logic [63:0] m, input logic [2:0] st);
    wb_valid = v;
    icode    = ic;
    ifun     = fn;
    cnd      = c;
    rA       = ra;
    rB       = rb;
    valE     = e;
    valM     = m;
    stat     = st;
  endtask

  task automatic idle();
    drive(1'b0, 4'h1, 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1);
  endtask

  initial begin
    reset = 1'b1;
    srcA  = 4'hF;
    srcB  = 4'hF;
    idle();
    tick();
    tick();
    reset = 1'b0;
    srcA  = 4'h2;
    #1;

    // Reset state
    check("rst_halted",  {63'b0, halted}, 64'd0);
    check("rst_wb_stat", {61'b0, wb_stat}, 64'd1);
    check("rst_retired", {32'b0, retired}, 64'd0);
    check("rst_r2",      rdA, 64'h0);

    // irmovq $0x1234, %r2
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h2, 64'h1234, 64'h0, 3'd1);
    #1;
    check("irmovq_dstE", {60'b0, dstE}, 64'h2);
    check("irmovq_dstM", {60'b0, dstM}, 64'hF);
`ifdef WB_BYPASS_EN
    check("irmovq_pre_rd", rdA, 64'h1234);
`else
    check("irmovq_pre_rd", rdA, 64'h0);
`endif
    tick();
    idle();
    #1;
    check("irmovq_r2",      rdA, 64'h1234);
    check("irmovq_retired", {32'b0, retired}, 64'd1);

    // popq %rsp: valM wins over valE on R4
    drive(1'b1, 4'hB, 4'h0, 1'b0, 4'h4, 4'hF, 64'h100, 64'h55, 3'd1);
    srcB = 4'h4;
    #1;
    check("popq_dstE", {60'b0, dstE}, 64'h4);
    check("popq_dstM", {60'b0, dstM}, 64'h4);
    tick();
    idle();
    #1;
    check("popq_r4",      rdB, 64'h55);
    check("popq_retired", {32'b0, retired}, 64'd2);

    // Preload R3 = 0x33
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h3, 64'h33, 64'h0, 3'd1);
    srcA = 4'h3;
    tick();

    // cmovle not taken: no destination, R3 kept, still retires
    drive(1'b1, 4'h2, 4'h1, 1'b0, 4'h1, 4'h3, 64'h99, 64'h0, 3'd1);
    #1;
    check("cmov_nt_dstE", {60'b0, dstE}, 64'hF);
    tick();
    idle();
    #1;
    check("cmov_nt_r3",      rdA, 64'h33);
    check("cmov_nt_retired", {32'b0, retired}, 64'd4);

    // cmovle taken writes R3
    drive(1'b1, 4'h2, 4'h1, 1'b1, 4'h1, 4'h3, 64'h77, 64'h0, 3'd1);
    #1;
    check("cmov_t_dstE", {60'b0, dstE}, 64'h3);
    tick();
    idle();
    #1;
    check("cmov_t_r3", rdA, 64'h77);

    // rrmovq (ifun 0) always has a destination, whatever cnd is
    drive(1'b0, 4'h2, 4'h0, 1'b0, 4'h1, 4'h9, 64'h0, 64'h0, 3'd1);
    #1;
    check("rrmovq_dstE", {60'b0, dstE}, 64'h9);

    // Bubble: destination still decoded, nothing written
    drive(1'b0, 4'h3, 4'h0, 1'b0, 4'hF, 4'h1, 64'hDEAD, 64'h0, 3'd1);
    srcA = 4'h1;
    #1;
    check("bubble_dstE", {60'b0, dstE}, 64'h1);
    tick();
    idle();
    #1;
    check("bubble_r1",      rdA, 64'h0);
    check("bubble_retired", {32'b0, retired}, 64'd5);

    // mrmovq writes valM to rA
    drive(1'b1, 4'h5, 4'h0, 1'b0, 4'h7, 4'hF, 64'h8, 64'h77AA, 3'd1);
    srcB = 4'h7;
    #1;
    check("mrmovq_dstM", {60'b0, dstM}, 64'h7);
    check("mrmovq_dstE", {60'b0, dstE}, 64'hF);
    tick();
    idle();
    #1;
    check("mrmovq_r7", rdB, 64'h77AA);

    // RNONE always reads 0
    srcB = 4'hF;
    #1;
    check("rnone_rd", rdB, 64'h0);

    // Write-through check on R6
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h6, 64'hAA, 64'h0, 3'd1);
    srcA = 4'h6;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_pre_r6", rdA, 64'hAA);
`else
    check("bypass_pre_r6", rdA, 64'h0);
`endif
    tick();
    idle();
    #1;
    check("bypass_post_r6",  rdA, 64'hAA);
    check("bypass_retired",  {32'b0, retired}, 64'd7);

    // Halt: HLT status with an irmovq to R5 writes nothing
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h5, 64'h55, 64'h0, 3'd2);
    srcA = 4'h5;
    #1;
    check("halt_pre_halted", {63'b0, halted}, 64'd0);
    tick();
    #1;
    check("halt_halted",  {63'b0, halted}, 64'd1);
    check("halt_wb_stat", {61'b0, wb_stat}, 64'd2);
    check("halt_r5",      rdA, 64'h0);
    check("halt_retired", {32'b0, retired}, 64'd7);

    // An AOK instruction in HALT is ignored
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h5, 64'h66, 64'h0, 3'd1);
    tick();
    #1;
    check("halted_ign_r5",      rdA, 64'h0);
    check("halted_ign_retired", {32'b0, retired}, 64'd7);
    check("halted_ign_wb_stat", {61'b0, wb_stat}, 64'd2);

    // An ADR status in HALT also leaves wb_stat held
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h5, 64'h66, 64'h0, 3'd3);
    tick();
    #1;
    check("halted_hold_stat", {61'b0, wb_stat}, 64'd2);
    check("halted_hold",      {63'b0, halted}, 64'd1);

    // Reset wins over a simultaneous commit and returns the stage to RUN
    reset = 1'b1;
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h5, 64'h66, 64'h0, 3'd1);
    srcB = 4'h2;
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("rerst_halted",  {63'b0, halted}, 64'd0);
    check("rerst_r5",      rdA, 64'h0);
    check("rerst_r2",      rdB, 64'h0);
    check("rerst_retired", {32'b0, retired}, 64'd0);
    check("rerst_wb_stat", {61'b0, wb_stat}, 64'd1);

    // Writes work again after reset
    drive(1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 4'h5, 64'h66, 64'h0, 3'd1);
    tick();
    idle();
    #1;
    check("run_again_r5",      rdA, 64'h66);
    check("run_again_retired", {32'b0, retired}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
